t05_sram_arbiter: RTL and testbench

Shares the single 32-bit SRAM port between the compression-side requesters: histogram, tree builder and codebook generator. Requests are arbitrated round-robin and presented to SRAM one at a time. Each transaction completes on an SRAM handshake and returns a one-cycle ack to the owner. A lock input keeps ownership across back-to-back transactions, so the histogram's read-increment-write sequence on one bin is atomic.

---
 rtl/t05_sram_arbiter.sv | 158 +++++++++++++++
 tb/tb_t05_sram_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t05_sram_arbiter.sv
// Round-robin arbiter sharing one 32-bit SRAM port between the histogram, tree builder
// and codebook requesters, with bounded lock chaining and a per-access timeout.
module t05_sram_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 8,
  parameter int TIMEOUT  = 16,
  parameter int LOCK_MAX = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*32-1:0]     wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [31:0]               rdata,
  output logic                      err,
  output logic                      busy,
  output logic                      sram_en,
  output logic                      sram_we,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic [31:0]               sram_wdata,
  input  logic [31:0]               sram_rdata,
  input  logic                      sram_ack
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LCK_W = $clog2(LOCK_MAX + 1);

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [LCK_W-1:0]   LOCK_LIM  = LCK_W'(LOCK_MAX);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_owner;
  logic [IDX_W-1:0]  r_last;
  logic [TMR_W-1:0]  r_timer;
  logic [LCK_W-1:0]  r_lock_cnt;

  logic              w_found;
  logic [IDX_W-1:0]  w_winner;
  logic [IDX_W-1:0]  w_src;
  logic              w_chain;
  logic [ADDR_W-1:0] w_addr_arr  [NUM_REQ];
  logic [31:0]       w_wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr_arr[g]  = addr[g*ADDR_W +: ADDR_W];
    assign w_wdata_arr[g] = wdata[g*32 +: 32];
  end

  // Scan starts just after the last owner, so a releasing requester is considered last.
  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    logic [IDX_W-1:0] v_idx;
    w_found  = 1'b0;
    w_winner = '0;
    v_idx    = r_last;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = (v_idx == LAST_IDX) ? '0 : v_idx + 1'b1;
      if (!w_found && req[v_idx]) begin
        w_found  = 1'b1;
        w_winner = v_idx;
      end
    end
  end

  // In IDLE the winner's inputs are latched; in DONE a locked owner relatches its own.
  assign w_src   = (r_state == IDLE) ? w_winner : r_owner;
  assign w_chain = lock[r_owner] && req[r_owner] && (r_lock_cnt < LOCK_LIM);

  // NOTE: non-blocking assignments throughout, so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_last     <= LAST_IDX;
      r_timer    <= '0;
      r_lock_cnt <= '0;
      gnt        <= '0;
      ack        <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      rdata      <= '0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_owner    <= w_winner;
            gnt        <= ONE_HOT0 << w_winner;
            sram_en    <= 1'b1;
            sram_we    <= we[w_src];
            sram_addr  <= w_addr_arr[w_src];
            sram_wdata <= w_wdata_arr[w_src];
            r_timer    <= '0;
            busy       <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (sram_ack) begin
            rdata   <= sram_rdata;
            sram_en <= 1'b0;
            ack     <= gnt;
            r_state <= DONE;
          end else if (r_timer == TMR_LAST) begin
            sram_en <= 1'b0;
            ack     <= gnt;
            err     <= 1'b1;
            r_state <= DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        DONE: begin
          if (w_chain) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
            sram_en    <= 1'b1;
            sram_we    <= we[w_src];
            sram_addr  <= w_addr_arr[w_src];
            sram_wdata <= w_wdata_arr[w_src];
            r_timer    <= '0;
            r_state    <= ISSUE;
          end else begin
            gnt        <= '0;
            r_last     <= r_owner;
            r_lock_cnt <= '0;
            busy       <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          gnt     <= '0;
          sram_en <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t05_sram_arbiter.sv
// Self-checking bench for t05_sram_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin and memory model.
module tb_t05_sram_arbiter;

  localparam int NR = 3;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0, we = '0, lock = '0;
  logic [NR*AW-1:0] addr = '0;
  logic [NR*32-1:0] wdata = '0;
  logic [NR-1:0] gnt, ack;
  logic [31:0]   rdata;
  logic          err, busy;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = '0;
  logic          sram_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // SRAM device model and its preload port
  logic [31:0] mem [256];
  int          dev_cnt   = 0;
  int          dev_delay = 1;
  bit          sram_mute = 1'b0;
  bit          pre_we    = 1'b0;
  logic [7:0]  pre_addr  = '0;
  logic [31:0] pre_data  = '0;

  t05_sram_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .err(err), .busy(busy),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ack(sram_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (!sram_en || sram_ack) begin
      dev_cnt  <= 0;
      sram_ack <= 1'b0;
    end else if (!sram_mute && (dev_cnt + 1 >= dev_delay)) begin
      sram_ack   <= 1'b1;
      sram_rdata <= mem[sram_addr];
      if (sram_we) mem[sram_addr] <= sram_wdata;
    end else begin
      dev_cnt <= dev_cnt + 1;
    end
  end

  function automatic int idx_of(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference arbitration rule: first set bit after the last owner, wrapping.
  function automatic int rr_pick(input logic [NR-1:0] m, input int last);
    for (int k = 1; k <= NR; k++) if (m[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic set_req(input int i, input bit r, input bit w, input bit l,
                         input logic [7:0] a, input logic [31:0] d);
    req[i] = r; we[i] = w; lock[i] = l;
    addr[i*AW +: AW] = a;
    wdata[i*32 +: 32] = d;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; we = '0; lock = '0; sram_mute = 1'b0; dev_delay = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(output int owner);
    int cyc;
    cyc = 0;
    owner = -1;
    do begin
      @(negedge clk);
      cyc++;
    end while (ack == '0 && cyc < 200);
    n_cmp++;
    if (ack == '0) begin
      n_bad++;
      $display("FAIL ack_wait: no ack seen after %0d cycles, wanted one", cyc);
    end else begin
      owner = idx_of(ack);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({gnt, ack, err, busy, sram_en, sram_we} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 0", {gnt, ack, err, busy, sram_en, sram_we});
    end
    n_cmp++;
    if ({sram_addr, sram_wdata, rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", {sram_addr, sram_wdata, rdata});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    preload(8'h41, 32'h5);
    set_req(0, 1, 0, 0, 8'h41, 32'h0);
    @(negedge clk);
    n_cmp++;
    if ({gnt, sram_en, sram_we, sram_addr} !== {3'b001, 1'b1, 1'b0, 8'h41}) begin
      n_bad++;
      $display("FAIL t1_grant: got gnt=%b en=%b we=%b addr=%h want 001 1 0 41",
               gnt, sram_en, sram_we, sram_addr);
    end
    req[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ack !== 3'b000) begin n_bad++; $display("FAIL t1_early_ack: got %b want 000", ack); end
    @(negedge clk);
    n_cmp++;
    if ({ack, err, rdata} !== {3'b001, 1'b0, 32'h5}) begin
      n_bad++;
      $display("FAIL t1_ack: got ack=%b err=%b rdata=%h want 001 0 5", ack, err, rdata);
    end
    @(negedge clk);
    n_cmp++;
    if ({ack, gnt, busy} !== 7'b0) begin
      n_bad++;
      $display("FAIL t1_release: got ack=%b gnt=%b busy=%b want 0", ack, gnt, busy);
    end
  endtask

  task automatic test_round_robin();
    int owner;
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1, 0, 0, 8'(8'h10 + i), 32'h0);
    for (int n = 0; n < 6; n++) begin
      wait_ack(owner);
      n_cmp++;
      if (owner != n % NR) begin
        n_bad++;
        $display("FAIL rr_order[%0d]: got owner %0d want %0d", n, owner, n % NR);
      end
    end
    req = '0;
  endtask

  task automatic test_lock_rmw();
    int owner;
    do_reset();
    preload(8'h42, 32'h7);
    set_req(1, 1, 0, 0, 8'h10, 32'h0);
    set_req(0, 1, 0, 1, 8'h42, 32'h0);
    wait_ack(owner);
    n_cmp++;
    if (owner != 0 || rdata !== 32'h7) begin
      n_bad++;
      $display("FAIL rmw_read: got owner %0d rdata %h want 0 7", owner, rdata);
    end
    we[0] = 1'b1;
    wdata[31:0] = 32'h8;
    @(negedge clk);
    n_cmp++;
    if ({gnt, sram_en, sram_we, sram_addr, sram_wdata} !== {3'b001, 1'b1, 1'b1, 8'h42, 32'h8}) begin
      n_bad++;
      $display("FAIL rmw_write_issue: got gnt=%b en=%b we=%b addr=%h wd=%h want 001 1 1 42 8",
               gnt, sram_en, sram_we, sram_addr, sram_wdata);
    end
    lock[0] = 1'b0;
    wait_ack(owner);
    n_cmp++;
    if (owner != 0 || gnt !== 3'b001) begin
      n_bad++;
      $display("FAIL rmw_write_ack: got owner %0d gnt %b want 0 001", owner, gnt);
    end
    req[0] = 1'b0;
    wait_ack(owner);
    n_cmp++;
    if (owner != 1) begin n_bad++; $display("FAIL rmw_next: got owner %0d want 1", owner); end
    n_cmp++;
    if (mem[8'h42] !== 32'h8) begin
      n_bad++;
      $display("FAIL rmw_mem: got %h want 8", mem[8'h42]);
    end
    req = '0;
  endtask

  task automatic test_lock_max();
    int owner;
    int exp_o [4] = '{0, 0, 0, 1};
    do_reset();
    set_req(0, 1, 0, 1, 8'h20, 32'h0);
    set_req(1, 1, 0, 0, 8'h21, 32'h0);
    for (int n = 0; n < 4; n++) begin
      wait_ack(owner);
      n_cmp++;
      if (owner != exp_o[n]) begin
        n_bad++;
        $display("FAIL lockmax[%0d]: got owner %0d want %0d", n, owner, exp_o[n]);
      end
    end
    req = '0; lock = '0;
  endtask

  task automatic test_timeout();
    int owner;
    int en_cyc;
    do_reset();
    preload(8'h41, 32'h5);
    set_req(1, 1, 0, 0, 8'h41, 32'h0);
    wait_ack(owner);
    set_req(1, 0, 0, 0, 8'h41, 32'h0);
    set_req(0, 1, 0, 0, 8'h30, 32'h0);
    set_req(2, 1, 0, 0, 8'h31, 32'h0);
    sram_mute = 1'b1;
    en_cyc = 0;
    for (int c = 0; c < 4 && !sram_en; c++) @(negedge clk);
    while (sram_en && en_cyc < 40) begin
      en_cyc++;
      @(negedge clk);
    end
    n_cmp++;
    if (en_cyc != 16) begin n_bad++; $display("FAIL to_len: got %0d cycles want 16", en_cyc); end
    n_cmp++;
    if ({ack, err, rdata} !== {3'b100, 1'b1, 32'h5}) begin
      n_bad++;
      $display("FAIL to_ack: got ack=%b err=%b rdata=%h want 100 1 5", ack, err, rdata);
    end
    sram_mute = 1'b0;
    req[2] = 1'b0;
    wait_ack(owner);
    n_cmp++;
    if (owner != 0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL to_next: got owner %0d err %b want 0 0", owner, err);
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    int owner;
    do_reset();
    sram_mute = 1'b1;
    set_req(1, 1, 0, 0, 8'h50, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({gnt, ack, err, busy, sram_en, sram_we, sram_addr, sram_wdata, rdata} !== '0) begin
      n_bad++;
      $display("FAIL rstmid_out: got gnt=%b ack=%b busy=%b en=%b want all 0", gnt, ack, busy, sram_en);
    end
    req[0] = 1'b1;
    sram_mute = 1'b0;
    rst = 1'b0;
    wait_ack(owner);
    n_cmp++;
    if (owner != 0) begin n_bad++; $display("FAIL rstmid_both: got owner %0d want 0", owner); end
    req[0] = 1'b0;
    sram_mute = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, sram_en, gnt} !== '0) begin
      n_bad++;
      $display("FAIL rstmid2_out: got busy=%b en=%b gnt=%b want 0", busy, sram_en, gnt);
    end
    sram_mute = 1'b0;
    rst = 1'b0;
    wait_ack(owner);
    n_cmp++;
    if (owner != 1) begin n_bad++; $display("FAIL rstmid_one: got owner %0d want 1", owner); end
    req = '0;
  endtask

  task automatic test_random();
    int owner, exp_o, last_m;
    logic [31:0] ref_mem [16];
    logic [NR-1:0] m;
    logic [7:0] a;
    do_reset();
    last_m = NR - 1;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      preload(8'(8'h80 + i), ref_mem[i]);
    end
    for (int n = 0; n < 60; n++) begin
      m = NR'($urandom_range(1, 7));
      for (int i = 0; i < NR; i++)
        set_req(i, m[i], 1'($urandom), 1'b0, 8'(8'h80 + $urandom_range(0, 15)), $urandom);
      dev_delay = $urandom_range(1, 4);
      wait_ack(owner);
      exp_o = rr_pick(m, last_m);
      n_cmp++;
      if (owner != exp_o || err !== 1'b0) begin
        n_bad++;
        $display("FAIL rnd_owner[%0d]: got owner %0d err %b want %0d 0", n, owner, err, exp_o);
      end
      if (exp_o >= 0) begin
        a = addr[exp_o*AW +: AW];
        n_cmp++;
        if (rdata !== ref_mem[a[3:0]]) begin
          n_bad++;
          $display("FAIL rnd_rdata[%0d]: got %h want %h", n, rdata, ref_mem[a[3:0]]);
        end
        if (we[exp_o]) ref_mem[a[3:0]] = wdata[exp_o*32 +: 32];
        last_m = exp_o;
      end
    end
    req = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (mem[8'h80 + i] !== ref_mem[i]) begin
        n_bad++;
        $display("FAIL rnd_mem[%0d]: got %h want %h", i, mem[8'h80 + i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock_rmw();
    test_lock_max();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
